// File: rtl/lc3_seq_alu.sv
// Multi-cycle LC-3 ALU: single-step ADD/AND/NOT/PASS, iterative MUL and shifts,
// valid/ready on both sides and a registered one-hot NZP condition code.
module lc3_seq_alu #(
    parameter int WIDTH  = 16,
    parameter int IMM_W  = 5,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             sr2mux,
    input  logic [IMM_W-1:0] imm,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0] imm_ext;
    logic signed [WIDTH-1:0] b_mux;
    logic signed [WIDTH-1:0] single;
    logic signed [WIDTH-1:0] work;
    logic signed [WIDTH-1:0] mcand;
    logic signed [WIDTH-1:0] step;
    logic        [WIDTH-1:0] mplier;
    logic        [SH_W-1:0]  sh;
    logic        [SH_W-1:0]  count;
    logic        [2:0]       op_reg;
    logic                    is_mul;
    logic                    is_shift;
    logic                    accept;

    function automatic logic [2:0] nzp(input logic signed [WIDTH-1:0] v);
        if (v == '0)
            return 3'b010;
        else if (v[WIDTH-1])
            return 3'b100;
        return 3'b001;
    endfunction

    // Shifts only reach this path with SH == 0, where the result is A itself.
    function automatic logic signed [WIDTH-1:0] single_step(
        input logic        [2:0]       o,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        case (o)
            OP_ADD:         return a + b;
            OP_AND:         return a & b;
            OP_NOT:         return ~a;
            OP_PASS:        return b;
            OP_SHL, OP_SRA: return a;
            default:        return '0;
        endcase
    endfunction

    assign imm_ext  = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    assign b_mux    = sr2mux ? imm_ext : src_b;
    assign sh       = b_mux[SH_W-1:0];
    assign is_mul   = (op == OP_MUL) && (MUL_EN != 0);
    assign is_shift = (op == OP_SHL) || (op == OP_SRA);
    assign single   = single_step(op, src_a, b_mux);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        step = work;
        case (op_reg)
            OP_MUL:  step = work + (mplier[0] ? mcand : '0);
            OP_SHL:  step = {work[WIDTH-2:0], 1'b0};
            OP_SRA:  step = {work[WIDTH-1], work[WIDTH-1:1]};
            default: step = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid)
                    state_next = (is_mul || (is_shift && sh != '0)) ? EXEC : DONE;
            end
            EXEC: begin
                if (count == '0)
                    state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // result/cc change only on entry to DONE, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            cc     <= 3'b010;
        end else if (accept && state_next == DONE) begin
            result <= single;
            cc     <= nzp(single);
        end else if (state == EXEC && count == '0) begin
            result <= step;
            cc     <= nzp(step);
        end
    end

    // count holds iterations remaining minus one: WIDTH-1 for MUL, SH-1 for shifts.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_reg <= op;
            mcand  <= src_a;
            mplier <= b_mux;
            work   <= is_mul ? '0 : src_a;
            count  <= is_mul ? SH_W'(WIDTH - 1) : sh - 1'b1;
        end else if (state == EXEC) begin
            work   <= step;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_lc3_seq_alu.sv
// Self-checking bench for lc3_seq_alu: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_lc3_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_valid0;
    logic         in_ready, in_ready0;
    logic [2:0]   op;
    logic         sr2mux;
    logic [4:0]   imm;
    logic [W-1:0] src_a, src_b;
    logic         out_valid, out_valid0;
    logic         out_ready, out_ready0;
    logic [W-1:0] result, result0;
    logic [2:0]   cc, cc0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lc3_seq_alu #(.WIDTH(W), .IMM_W(5), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sr2mux(sr2mux), .imm(imm), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .cc(cc)
    );

    lc3_seq_alu #(.WIDTH(W), .IMM_W(5), .MUL_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .op(op), .sr2mux(sr2mux), .imm(imm), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid0), .out_ready(out_ready0), .result(result0), .cc(cc0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input bit mul_en);
        logic [31:0] prod;
        int          sh;
        sh   = int'(b[3:0]);
        prod = 32'(a) * 32'(b);
        case (o)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return ~a;
            3'd3: return b;
            3'd4: return mul_en ? prod[W-1:0] : '0;
            3'd5: return a << sh;
            3'd6: return W'($signed(a) >>> sh);
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [W-1:0] b, input bit mul_en);
        if (o == 3'd4 && mul_en) return W;
        if (o == 3'd5 || o == 3'd6) return int'(b[3:0]);
        return 0;
    endfunction

    function automatic logic [2:0] ref_cc(input logic [W-1:0] v);
        if (v == 0) return 3'b010;
        if ($signed(v) < 0) return 3'b100;
        return 3'b001;
    endfunction

    // Entered and left at #1 after an edge with the DUT idle.
    task automatic run_op(input logic [2:0] o, input logic s2, input logic [4:0] im,
                          input logic [W-1:0] a, input logic [W-1:0] bsrc, input int hold,
                          output logic [W-1:0] r_obs, output logic [2:0] c_obs);
        logic [W-1:0] b, exp_r;
        logic [2:0]   exp_c;
        int           n;
        b     = s2 ? {{11{im[4]}}, im} : bsrc;
        exp_r = ref_result(o, a, b, 1'b1);
        exp_c = ref_cc(exp_r);
        n     = ref_latency(o, b, 1'b1);
        check("in_ready_idle", in_ready, 1);
        op = o; sr2mux = s2; imm = im; src_a = a; src_b = bsrc;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); sr2mux = 1'($urandom); imm = 5'($urandom);
        src_a = W'($urandom); src_b = W'($urandom);
        for (int k = 1; k <= n; k++) begin
            check("busy_out_valid", out_valid, 0);
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        check("done_out_valid", out_valid, 1);
        check("done_in_ready", in_ready, 0);
        check("result", result, exp_r);
        check("cc", cc, exp_c);
        r_obs = result;
        c_obs = cc;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", result, exp_r);
            check("hold_cc", cc, exp_c);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r;
        logic [2:0]   c;
        rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b0; out_ready0 = 1'b0;
        op = '0; sr2mux = 1'b0; imm = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 16'h0000);
        check("rst_cc", cc, 3'b010);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 1'b1, 5'b11111, 16'h0005, 16'h0000, 0, r, c);
        check("add_imm_val", r, 16'h0004);
        check("add_imm_cc", c, 3'b001);
        run_op(3'd1, 1'b0, 5'd0, 16'h00F0, 16'h0F00, 0, r, c);
        check("and_val", r, 16'h0000);
        check("and_cc", c, 3'b010);
        run_op(3'd4, 1'b0, 5'd0, 16'h0003, 16'hFFFE, 0, r, c);
        check("mul_val", r, 16'hFFFA);
        check("mul_cc", c, 3'b100);
        run_op(3'd6, 1'b0, 5'd0, 16'h8000, 16'h000F, 0, r, c);
        check("sra15_val", r, 16'hFFFF);
        check("sra15_cc", c, 3'b100);
        run_op(3'd5, 1'b0, 5'd0, 16'h1234, 16'h0000, 0, r, c);
        check("shl0_val", r, 16'h1234);
        run_op(3'd5, 1'b0, 5'd0, 16'h0001, 16'h0013, 0, r, c);
        check("shl3_val", r, 16'h0008);
        run_op(3'd2, 1'b0, 5'd0, 16'h00FF, 16'h0000, 5, r, c);
        check("not_bp_val", r, 16'hFF00);
        check("not_bp_cc", c, 3'b100);
        run_op(3'd7, 1'b0, 5'd0, 16'h1234, 16'h5678, 1, r, c);
        check("reserved_val", r, 16'h0000);

        // Reset during the seventh EXEC cycle of a MUL.
        op = 3'd4; sr2mux = 1'b0; src_a = 16'h0003; src_b = 16'h0005; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        check("mid_mul_busy", in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 16'h0000);
        check("midrst_cc", cc, 3'b010);
        check("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 1'b0, 5'd0, 16'h0001, 16'h0001, 0, r, c);
        check("add_after_rst", r, 16'h0002);

        // MUL opcode on the build without a multiplier.
        check("m0_in_ready", in_ready0, 1);
        op = 3'd4; sr2mux = 1'b0; src_a = 16'h0003; src_b = 16'h0004; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        check("m0_out_valid", out_valid0, 1);
        check("m0_result", result0, 16'h0000);
        check("m0_cc", cc0, 3'b010);
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        check("m0_post_hs", in_ready0, 1);
        out_ready0 = 1'b0;

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
            run_op(3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom), a, b,
                   $urandom_range(0, 3), r, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
